sinc3_mc_decimator: RTL and testbench
=====================================

// Module: sinc3_mc_decimator
// PURPOSE
//  Multi-channel sinc3 decimator for isolated sigma-delta modulator bitstreams.
//  NUM_CH 1-bit streams are sampled on one modulator clock, filtered by parallel 3rd-order CIC, and decimated at a runtime-selectable rate R = 2^k.
//  Results are emitted as a channel-tagged word stream with a valid/ready handshake to the current/voltage sensing logic.
// PARAMETERS
//  NUM_CH     4    number of modulator channels (1..16)
//  MAX_K      12   largest log2 decimation rate supported
//  ACC_W      37   integrator/comb width = 3*MAX_K+1
//  OUT_W      16   output word width
// PORTS
//  mclk1      in   1              modulator clock; all logic on rising edge
//  reset      in   1              asynchronous, active-low reset
//  mdata      in   NUM_CH         modulator bits, bit i = channel i
//  dec_sel    in   4              requested k (R=2^k), valid 5..MAX_K
//  out_data   out  OUT_W          filtered unsigned sample
//  out_ch     out  $clog2(NUM_CH) channel index of out_data
//  out_valid  out  1              out_data/out_ch valid
//  out_ready  in   1              consumer accepts word when high with out_valid
//  ovr        out  1              sticky overrun flag
//  clr_ovr    in   1              synchronous clear of ovr
//  cfg_err    out  1              dec_sel outside 5..MAX_K
// BEHAVIOUR
//  Reset (reset=0): integrators, combs, word counter, frame buffer = 0.
//   out_valid=0, out_ch=0, out_data=0, ovr=0, cfg_err=0; active k=MAX_K.
//   Settle count=3; on release the first 3 frames are suppressed.
//  Input map: bit 0 -> 0, bit 1 -> +1 (unsigned). Full scale = 2^(3k).
//  Integrators: every cycle, per channel, 3 cascaded ACC_W adders.
//   Wrap mod 2^ACC_W is intended; no saturation.
//  Word counter 0..R-1; tick on the cycle count==R-1.
//   On tick, the comb chain per channel (diff1..3 with delay regs) updates at the next edge.
//   The scaled frame loads into the NUM_CH-entry buffer one edge later.
//   out_valid rises 2 cycles after the tick, out_ch=0.
//  Scaling: s=3k-OUT_W. s>=0: out = diff3>>s. s<0: out = diff3<<(-s).
//   If diff3 >= 2^(3k) (exact full scale), out = all ones.
//  Settle: while settle count>0, frame load is skipped and the count decrements.
//   Suppressed frames never assert out_valid.
//  Rate change: dec_sel is registered each cycle.
//   If valid and != active k, the new k is applied at the next tick.
//   At that point: counter restarts at 0, settle count=3, integrators untouched, comb delay regs cleared.
//   If invalid: cfg_err=1, request ignored, active k kept.
//  Handshake: a word transfers when out_valid & out_ready; out_ch then increments.
//   After transfer of ch NUM_CH-1, out_valid drops unless a new frame loads in the same cycle.
//   out_data/out_ch are stable while out_valid & ~out_ready.
//  Overrun: a frame load while any word of the prior frame is untransferred sets ovr=1.
//   The buffer is overwritten and the stream restarts at ch0.
//   Last-word transfer in the same cycle as a load is not an overrun.
//   clr_ovr and an overrun in the same cycle -> ovr=1 (set wins).
//  Reset mid-operation: out_valid drops asynchronously; pending frame discarded; settle restarts.
// STRUCTURE
//  Package sinc3_pkg: K_MIN=5, SETTLE_FRAMES=3, function acc_w(max_k), scale/shift helper.
//  Sub-module sinc3_channel: one channel's integrators + comb + scaling, output valid on frame strobe.
//  Top: instantiates NUM_CH sinc3_channel; owns word counter, rate/settle control, frame buffer, handshake.
// TESTING
//  1 all mdata=0, dec_sel=6, out_ready=1 -> after 3 suppressed frames every word 0x0000, out_ch 0..3 in order.
//  2 ch0 all ones, dec_sel=8 -> ch0 words 0xFFFF (saturated 2^24); other channels 0x0000.
//  3 ch1 alternating 1/0, dec_sel=6 -> ch1 settles to 0x8000; dec_sel=5 -> 0x8000 via left shift.
//  4 dec_sel 6->5 mid-frame -> no output until next tick + 3 frames, then frames every 32 cycles.
//  5 out_ready=0 across two ticks -> ovr=1, stream restarts at ch0; clr_ovr pulse -> ovr=0.
//  6 reset low during drain of ch2 -> out_valid=0 immediately; after release 3 frames suppressed; dec_sel=3 -> cfg_err=1, rate unchanged.

Source files
------------

// File: rtl/sinc3_pkg.sv
// Shared constants and helpers for the multi-channel sinc3 decimator.
package sinc3_pkg;

    localparam int K_MIN         = 5;
    localparam int SETTLE_FRAMES = 3;
    localparam int SETTLE_W      = $clog2(SETTLE_FRAMES + 1);

    // Integrator/comb width that holds a full-scale 3rd-order sum at 2^max_k.
    function automatic int acc_w(input int max_k);
        return 3 * max_k + 1;
    endfunction

    // Right-shift that maps a 3k-bit full scale onto out_w bits (negative = left shift).
    function automatic int shift_amt(input int k, input int out_w);
        return 3 * k - out_w;
    endfunction

endpackage

// File: rtl/sinc3_channel.sv
// One modulator channel: three free-running integrators, a three-stage comb
// updated once per decimation frame, and scaling of the comb result to OUT_W.
module sinc3_channel
    import sinc3_pkg::*;
#(
    parameter int ACC_W = 37,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             comb_en,
    input  logic             comb_clr,
    input  logic [3:0]       k,
    output logic [OUT_W-1:0] sample
);

    logic [ACC_W-1:0] int1, int2, int3;
    logic [ACC_W-1:0] dly1, dly2, dly3;
    logic [ACC_W-1:0] diff1, diff2, diff3;
    logic [ACC_W-1:0] full_scale;
    int               shift;

    // Integrator cascade; wraps modulo 2^ACC_W, which the combs undo exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1 <= '0;
            int2 <= '0;
            int3 <= '0;
        end else begin
            int1 <= int1 + ACC_W'(bit_in);
            int2 <= int2 + int1;
            int3 <= int3 + int2;
        end
    end

    // First two comb differences, evaluated against the stored delays.
    always_comb begin
        diff1 = int3 - dly1;
        diff2 = diff1 - dly2;
    end

    // Comb delays and final difference advance once per frame; a rate change clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly1  <= '0;
            dly2  <= '0;
            dly3  <= '0;
            diff3 <= '0;
        end else if (comb_clr) begin
            dly1  <= '0;
            dly2  <= '0;
            dly3  <= '0;
            diff3 <= '0;
        end else if (comb_en) begin
            dly1  <= int3;
            dly2  <= diff1;
            dly3  <= diff2;
            diff3 <= diff2 - dly3;
        end
    end

    // Scale 3k-bit result to OUT_W; exact full scale would overflow, so pin it to all ones.
    always_comb begin
        shift      = shift_amt(int'(k), OUT_W);
        full_scale = ACC_W'(1) << (3 * int'(k));
        if (diff3 >= full_scale) begin
            sample = '1;
        end else if (shift >= 0) begin
            sample = OUT_W'(diff3 >> shift);
        end else begin
            sample = OUT_W'(diff3 << (-shift));
        end
    end

endmodule

// File: rtl/sinc3_mc_decimator.sv
// Multi-channel sinc3 decimator: shared word counter and rate/settle control,
// per-channel filters, a frame buffer and a channel-tagged valid/ready stream.
// Stream contract: a word moves on any edge where out_valid & out_ready; while
// out_valid is high and out_ready low, out_data/out_ch hold their values.
module sinc3_mc_decimator
    import sinc3_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int MAX_K  = 12,
    parameter int ACC_W  = acc_w(MAX_K),
    parameter int OUT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              mclk1,
    input  logic              reset,
    input  logic [NUM_CH-1:0] mdata,
    input  logic [3:0]        dec_sel,
    output logic [OUT_W-1:0]  out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovr,
    input  logic              clr_ovr,
    output logic              cfg_err
);

    logic [3:0]          dec_q;
    logic [3:0]          k_act;
    logic [MAX_K-1:0]    cnt;
    logic [MAX_K-1:0]    cnt_last;
    logic [SETTLE_W-1:0] settle;
    logic                req_ok, pending, tick;
    logic                comb_en, comb_clr, strobe, load;
    logic                xfer, last_xfer;
    logic [OUT_W-1:0]    sample    [NUM_CH];
    logic [OUT_W-1:0]    frame_buf [NUM_CH];

    // Frame timing, rate-change request and handshake decode.
    always_comb begin
        req_ok    = (dec_q >= 4'(K_MIN)) && (dec_q <= 4'(MAX_K));
        pending   = req_ok && (dec_q != k_act);
        cnt_last  = (MAX_K'(1) << k_act) - MAX_K'(1);
        tick      = (cnt == cnt_last);
        comb_en   = tick && !pending;
        comb_clr  = tick && pending;
        load      = strobe && (settle == '0);
        xfer      = out_valid && out_ready;
        last_xfer = xfer && (out_ch == CH_W'(NUM_CH - 1));
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sinc3_channel #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_ch (
            .clk      (mclk1),
            .rst_n    (reset),
            .bit_in   (mdata[i]),
            .comb_en  (comb_en),
            .comb_clr (comb_clr),
            .k        (k_act),
            .sample   (sample[i])
        );
    end

    // Word counter, active rate and settle countdown; a rate-change tick yields no frame.
    always_ff @(posedge mclk1 or negedge reset) begin
        if (!reset) begin
            dec_q   <= 4'(MAX_K);
            k_act   <= 4'(MAX_K);
            cnt     <= '0;
            settle  <= SETTLE_W'(SETTLE_FRAMES);
            strobe  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            dec_q   <= dec_sel;
            cfg_err <= !req_ok;
            strobe  <= comb_en;
            cnt     <= tick ? '0 : cnt + MAX_K'(1);
            if (comb_clr) begin
                k_act  <= dec_q;
                settle <= SETTLE_W'(SETTLE_FRAMES);
            end else if (strobe && (settle != '0)) begin
                settle <= settle - SETTLE_W'(1);
            end
        end
    end

    // Frame buffer, output channel pointer and sticky overrun (set beats clear).
    always_ff @(posedge mclk1 or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            ovr       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) frame_buf[i] <= '0;
        end else begin
            if (load) begin
                for (int i = 0; i < NUM_CH; i++) frame_buf[i] <= sample[i];
                out_valid <= 1'b1;
                out_ch    <= '0;
            end else if (last_xfer) begin
                out_valid <= 1'b0;
                out_ch    <= '0;
            end else if (xfer) begin
                out_ch <= out_ch + CH_W'(1);
            end
            if (load && out_valid && !last_xfer) begin
                ovr <= 1'b1;
            end else if (clr_ovr) begin
                ovr <= 1'b0;
            end
        end
    end

    assign out_data = frame_buf[out_ch];

endmodule

// File: tb/tb_sinc3_mc_decimator.sv
// Directed bench for sinc3_mc_decimator: expected words are queued per frame
// and compared as the stream delivers them; timing and flags checked inline.
`timescale 1ns/1ps
module tb_sinc3_mc_decimator;

    localparam int NUM_CH = 4;
    localparam int MAX_K  = 12;
    localparam int OUT_W  = 16;
    localparam int CH_W   = 2;

    // ---------------- clock / reset / stimulus signals ----------------
    logic              mclk1      = 1'b0;
    logic              reset      = 1'b1;
    logic [NUM_CH-1:0] mdata_base = '0;
    logic              alt_en     = 1'b0;
    logic              alt_bit    = 1'b0;
    logic [NUM_CH-1:0] mdata;
    logic [3:0]        dec_sel    = 4'd6;
    logic              out_ready  = 1'b1;
    logic              clr_ovr    = 1'b0;
    logic [OUT_W-1:0]  out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_valid;
    logic              ovr;
    logic              cfg_err;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    logic [CH_W+OUT_W-1:0] exp_q[$];
    bit mon_arm  = 1'b0;
    bit mon_sync = 1'b0;

    assign mdata = mdata_base | (alt_en ? {2'b00, alt_bit, 1'b0} : 4'b0000);

    always #5 mclk1 = ~mclk1;
    always @(posedge mclk1) cyc++;

    // Channel 1 alternating pattern, changing just after each rising edge.
    initial forever begin
        @(posedge mclk1);
        #1;
        alt_bit = ~alt_bit;
    end

    sinc3_mc_decimator #(
        .NUM_CH (NUM_CH),
        .MAX_K  (MAX_K),
        .OUT_W  (OUT_W)
    ) dut (
        .mclk1     (mclk1),
        .reset     (reset),
        .mdata     (mdata),
        .dec_sel   (dec_sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovr       (ovr),
        .clr_ovr   (clr_ovr),
        .cfg_err   (cfg_err)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge mclk1);
            #1;
        end
    endtask

    task automatic push_frame(input logic [OUT_W-1:0] d0, input logic [OUT_W-1:0] d1,
                              input logic [OUT_W-1:0] d2, input logic [OUT_W-1:0] d3);
        exp_q.push_back({2'd0, d0});
        exp_q.push_back({2'd1, d1});
        exp_q.push_back({2'd2, d2});
        exp_q.push_back({2'd3, d3});
    endtask

    // Wait for the next 0->1 transition of out_valid; at = cycle stamp of the rise.
    task automatic wait_rise(input string tag, input int limit, output int at);
        bit prev;
        bit found;
        found = 1'b0;
        at    = -1;
        @(negedge mclk1);
        prev = out_valid;
        for (int n = 0; n < limit && !found; n++) begin
            @(negedge mclk1);
            if (out_valid && !prev) begin
                found = 1'b1;
                at    = cyc;
            end
            prev = out_valid;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic expect_frames(input string tag, input int nframes,
                                 input logic [OUT_W-1:0] d0, input logic [OUT_W-1:0] d1,
                                 input logic [OUT_W-1:0] d2, input logic [OUT_W-1:0] d3,
                                 input int limit);
        int n;
        step(1);
        mon_sync = 1'b0;
        for (int f = 0; f < nframes; f++) push_frame(d0, d1, d2, d3);
        mon_arm = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge mclk1);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        mon_arm = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [CH_W+OUT_W-1:0] e;
        forever begin
            @(negedge mclk1);
            if (mon_arm && reset && out_valid && out_ready) begin
                if (out_ch == '0) mon_sync = 1'b1;
                if (mon_sync && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("word_ch", 32'(out_ch), 32'(e[OUT_W +: CH_W]));
                    check("word_data", 32'(out_data), 32'(e[OUT_W-1:0]));
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int rel, r0, r1, r2, n;
        bit seen;

        // Reset values, all-zero input, k=6 requested.
        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        repeat (3) @(negedge mclk1);
        reset = 1'b1;
        rel = cyc;

        // Default k=12 runs one frame, switch to k=6, then three suppressed frames.
        wait_rise("t1_first_rise", 5000, r0);
        check("t1_first_rise_cycle", 32'(r0 - rel), 32'd4353);
        expect_frames("t1_zero_frames", 2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 400);

        // Channel 0 all ones at k=8: exact full scale pins to all ones.
        step(1);
        mdata_base = 4'b0001;
        dec_sel    = 4'd8;
        step(1400);
        expect_frames("t2_full_scale", 2, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 700);

        // Channel 1 alternating at k=6: half scale.
        step(1);
        mdata_base = 4'b0000;
        alt_en     = 1'b1;
        dec_sel    = 4'd6;
        step(800);
        expect_frames("t3_half_k6", 2, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 300);

        // Mid-frame change 6 -> 5: silent until next tick plus three frames, then every 32.
        wait_rise("t4_rise0", 100, r0);
        step(10);
        dec_sel = 4'd5;
        wait_rise("t4_rise1", 400, r1);
        wait_rise("t4_rise2", 100, r2);
        check("t4_gap_after_change", 32'(r1 - r0), 32'd192);
        check("t4_frame_period", 32'(r2 - r1), 32'd32);
        step(40);
        expect_frames("t3_half_k5", 2, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 200);

        // Overrun: one word taken, then stall across a frame load.
        wait_rise("t5_rise", 100, r0);
        @(posedge mclk1);
        #1;
        out_ready = 1'b0;
        @(negedge mclk1);
        check("t5_stall_ch", 32'(out_ch), 32'd1);
        check("t5_stall_valid", 32'(out_valid), 32'd1);
        check("t5_no_ovr_yet", 32'(ovr), 32'd0);
        seen = 1'b0;
        for (n = 0; n < 40 && !seen; n++) begin
            @(negedge mclk1);
            seen = ovr;
        end
        check("t5_ovr_set", 32'(seen), 32'd1);
        check("t5_restart_ch", 32'(out_ch), 32'd0);
        check("t5_restart_valid", 32'(out_valid), 32'd1);
        @(posedge mclk1);
        #1;
        out_ready = 1'b1;
        clr_ovr   = 1'b1;
        @(posedge mclk1);
        #1;
        clr_ovr = 1'b0;
        @(negedge mclk1);
        check("t5_ovr_cleared", 32'(ovr), 32'd0);
        // Clear held high while an overrun happens: set must win.
        @(posedge mclk1);
        #1;
        clr_ovr   = 1'b1;
        out_ready = 1'b0;
        seen = 1'b0;
        for (n = 0; n < 80; n++) begin
            @(negedge mclk1);
            if (ovr) seen = 1'b1;
        end
        check("t5_set_wins", 32'(seen), 32'd1);
        @(posedge mclk1);
        #1;
        clr_ovr   = 1'b0;
        out_ready = 1'b1;

        // Reset while channel 2 is on the bus.
        seen = 1'b0;
        for (n = 0; n < 100 && !seen; n++) begin
            @(negedge mclk1);
            seen = out_valid && (out_ch == 2'd2);
        end
        check("t6_found_ch2", 32'(seen), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_ch", 32'(out_ch), 32'd0);
        check("t6_async_ovr", 32'(ovr), 32'd0);
        repeat (3) @(negedge mclk1);
        reset = 1'b1;
        rel = cyc;
        wait_rise("t6_first_rise", 5000, r0);
        check("t6_first_rise_cycle", 32'(r0 - rel), 32'd4225);
        expect_frames("t6_half_k5", 1, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 200);

        // Invalid request flags an error and leaves the rate alone.
        step(1);
        dec_sel = 4'd3;
        step(3);
        check("t6_cfg_err_set", 32'(cfg_err), 32'd1);
        wait_rise("t6_rise_a", 200, r1);
        wait_rise("t6_rise_b", 200, r2);
        check("t6_rate_kept", 32'(r2 - r1), 32'd32);
        step(1);
        dec_sel = 4'd5;
        step(3);
        check("t6_cfg_err_clear", 32'(cfg_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
